bus_sequencer: RTL and testbench
================================

Name: bus_sequencer

Overview:
Fetch/decode/execute control FSM for the 8-bit common-bus CPU. Sits directly downstream of the instruction register and consumes its opcode. Drives every load enable, bus source select, register-file access and ALU op for the PC, IR, register file and A/B operand registers. Handles the instruction-memory request/acknowledge handshake, including a timeout.

Parameters:
TIMEOUT_CYCLES, 16, cycles mem_req may stay high without mem_ack before a fault (legal range 2..255)
HALT_ON_ILLEGAL, 0, 1 = an illegal opcode halts; 0 = it executes as NOP

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
ir  input  8  current instruction from the instruction register
alu_zero  input  1  ALU result == 0, valid in WB
mem_ack  input  1  memory data valid on mem_rdata this cycle
mem_req  output  1  memory read request at address = pc
bus_sel  output  3  bus source: 0 none, 1 PC, 2 MEM, 3 RF r_data, 4 ALU
pc_load_en  output  1  PC load enable
pc_src  output  1  PC next: 0 = pc+1, 1 = bus
ir_load_en  output  1  IR load enable (IR loads from bus)
rf_write_read  output  1  1 = write w_data=bus; 0 = read (data next cycle)
rf_address  output  2  register-file address
a_load_en  output  1  operand register A load from bus
b_load_en  output  1  operand register B load from bus
alu_op  output  3  ALU operation
z_flag  output  1  latched zero flag
halted  output  1  sequencer in HALT
fault  output  1  sticky memory-timeout fault
illegal_op  output  1  one-cycle pulse on illegal opcode decode

Behaviour:
- Encoding: ir[7]=1 means ALU op, alu_op=ir[6:4], rd=ir[3:2], rs=ir[1:0], and rd <= rd op rs. Otherwise ir[7:4] selects: 0x0 NOP, 0x1 LDI rd,#imm8 (2 bytes), 0x2 MOV rd,rs, 0x3 JMP imm8, 0x4 JZ imm8, 0x7 HALT. 0x5/0x6 are illegal.
- States: FETCH, DECODE, RD_A, RD_B, EXEC, WB, MOV_WB, IMM, HALT.
- Reset: state=FETCH. z_flag, halted, fault, illegal_op = 0. All enables 0, bus_sel=0, alu_op=0, rf_address=0. Reset overrides every state, including mid-handshake (mem_req drops the next cycle).
- Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, held until mem_ack.
  - In the ack cycle: bus_sel=2, ir_load_en=1, pc_load_en=1, pc_src=0; next state DECODE. Enables are combinational on mem_ack.
  - Ack in the same cycle as the first request is legal (1-cycle fetch).
- DECODE: one cycle, no enables.
  - ALU op -> RD_A.
  - MOV -> RD_A.
  - LDI/JMP/JZ -> IMM.
  - HALT -> HALT.
  - NOP -> FETCH.
  - Illegal: illegal_op=1 for this cycle, then FETCH (or HALT if HALT_ON_ILLEGAL=1).
- RD_A: rf_address = rd for ALU, rs for MOV; read. Next: RD_B (ALU) or MOV_WB (MOV).
- RD_B: rf_address=rs, read; bus_sel=3, a_load_en=1 (captures rd value).
- EXEC: bus_sel=3, b_load_en=1 (captures rs value); alu_op driven.
- WB: alu_op driven, bus_sel=4, rf_address=rd, rf_write_read=1; z_flag <= alu_zero; then FETCH.
- MOV_WB: bus_sel=3, rf_address=rd, rf_write_read=1; then FETCH. z_flag is unchanged.
- IMM: mem_req=1 until ack. In the ack cycle bus_sel=2, then FETCH.
  - LDI: rf write rd, pc_load_en=1, pc_src=0.
  - JMP: pc_load_en=1, pc_src=1.
  - JZ: pc_load_en=1, pc_src=z_flag.
- Latency with 1-cycle ack: NOP 2, ALU 6, MOV 4, LDI/JMP/JZ 3.
- Timeout: an 8-bit counter clears on each new request and increments each cycle mem_req=1 && !mem_ack. On reaching TIMEOUT_CYCLES-1 without ack: fault<=1, go to HALT, mem_req drops. An ack in that same cycle wins (no fault).
- HALT: halted=1, no enables, stays until reset. fault is sticky until reset.
- The IR is only updated in FETCH, so ir is stable from DECODE through the end of the instruction.

Optional Feature:
SEQ_STEP_EN: adds an input port step (1 bit).
- Defined: FETCH does not assert mem_req until a cycle with step=1. Exactly one instruction executes per step pulse. step is ignored outside FETCH and while a request is already outstanding. The timeout counter does not run while waiting for step.
- Undefined: no step port; FETCH requests immediately (free-running).

Test Plan:
- Reset, then mem_ack tied 1, fetch byte 0x14 then 0x5A -> LDI r1: rf write addr 1 with bus_sel=2 at cycle 3, pc incremented twice, back in FETCH.
- ALU op 0x86 (alu_op 0, rd=1, rs=2) -> RD_A addr 1, RD_B addr 2 with a_load_en, EXEC b_load_en, WB rf write addr 1 with bus_sel=4; alu_zero=1 in WB -> z_flag=1.
- With z_flag=1, JZ 0x40 + imm 0x20 -> pc_src=1 in imm ack cycle. Repeat with z_flag=0 -> pc_src=0.
- mem_ack withheld for TIMEOUT_CYCLES=16 cycles -> fault=1, halted=1, mem_req=0. Ack on cycle 15 instead -> no fault.
- Opcode 0x50 with HALT_ON_ILLEGAL=0 -> illegal_op pulses 1 cycle, next FETCH. With HALT_ON_ILLEGAL=1 -> halted=1.
- reset asserted in EXEC and in the middle of FETCH wait -> next cycle state FETCH with all outputs at reset values; 0x70 -> halted=1 held until reset.

Source files
------------

// File: rtl/bus_sequencer_if.sv
// Handshake and control bundle between the instruction sequencer and the
// common-bus datapath (IR, PC, register file, A/B operands, ALU).
`default_nettype none

interface bus_sequencer_if;
  logic [7:0] ir;
  logic       alu_zero;
  logic       mem_ack;
  logic       mem_req;
  logic [2:0] bus_sel;
  logic       pc_load_en;
  logic       pc_src;
  logic       ir_load_en;
  logic       rf_write_read;
  logic [1:0] rf_address;
  logic       a_load_en;
  logic       b_load_en;
  logic [2:0] alu_op;
  logic       z_flag;
  logic       halted;
  logic       fault;
  logic       illegal_op;

  modport master (
    input  ir, alu_zero, mem_ack,
    output mem_req, bus_sel, pc_load_en, pc_src, ir_load_en, rf_write_read,
           rf_address, a_load_en, b_load_en, alu_op, z_flag, halted, fault,
           illegal_op
  );

  modport slave (
    output ir, alu_zero, mem_ack,
    input  mem_req, bus_sel, pc_load_en, pc_src, ir_load_en, rf_write_read,
           rf_address, a_load_en, b_load_en, alu_op, z_flag, halted, fault,
           illegal_op
  );
endinterface

`default_nettype wire

// File: rtl/bus_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module  : bus_sequencer                                                  |
// | Desc    : fetch/decode/execute control FSM for the 8-bit common-bus CPU  |
// |           with memory-request timeout. Optional macro SEQ_STEP_EN adds   |
// |           a single-step input gating each instruction fetch.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module bus_sequencer #(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
`ifdef SEQ_STEP_EN
  input  logic            step,
`endif
  bus_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_RD_A   = 4'd2,
    S_RD_B   = 4'd3,
    S_EXEC   = 4'd4,
    S_WB     = 4'd5,
    S_MOV_WB = 4'd6,
    S_IMM    = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_ldi  = 4'h1;
  localparam logic [3:0] c_op_mov  = 4'h2;
  localparam logic [3:0] c_op_jmp  = 4'h3;
  localparam logic [3:0] c_op_jz   = 4'h4;
  localparam logic [3:0] c_op_halt = 4'h7;

  localparam logic [2:0] c_bus_mem = 3'd2;
  localparam logic [2:0] c_bus_rf  = 3'd3;
  localparam logic [2:0] c_bus_alu = 3'd4;

  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic       z_flag_q, z_flag_d;
  logic       fault_q, fault_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  logic       w_fetch_go;
  logic       w_mem_req;
  logic       w_timeout;
  logic [3:0] w_opc;
  logic [1:0] w_rd;
  logic [1:0] w_rs;

  logic [2:0] w_bus_sel;
  logic       w_pc_load_en;
  logic       w_pc_src;
  logic       w_ir_load_en;
  logic       w_rf_write_read;
  logic [1:0] w_rf_address;
  logic       w_a_load_en;
  logic       w_b_load_en;
  logic [2:0] w_alu_op;
  logic       w_illegal_op;

  assign w_opc = bus.ir[7:4];
  assign w_rd  = bus.ir[3:2];
  assign w_rs  = bus.ir[1:0];

`ifdef SEQ_STEP_EN
  // Once a step pulse has launched a request, hold it until ack or timeout.
  logic step_armed_q;
  logic step_armed_d;

  assign w_fetch_go   = step_armed_q | step;
  assign step_armed_d = (state_q == S_FETCH) && w_fetch_go && !bus.mem_ack && !w_timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      step_armed_q <= 1'b0;
    end else begin
      step_armed_q <= step_armed_d;
    end
  end
`else
  assign w_fetch_go = 1'b1;
`endif

  assign w_mem_req = ((state_q == S_FETCH) && w_fetch_go) || (state_q == S_IMM);
  assign w_timeout = w_mem_req && !bus.mem_ack && (tmo_cnt_q == c_tmo_last);
  assign tmo_cnt_d = (w_mem_req && !bus.mem_ack) ? tmo_cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      z_flag_q  <= 1'b0;
      fault_q   <= 1'b0;
      tmo_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      z_flag_q  <= z_flag_d;
      fault_q   <= fault_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    z_flag_d        = z_flag_q;
    fault_d         = fault_q;
    w_bus_sel       = 3'd0;
    w_pc_load_en    = 1'b0;
    w_pc_src        = 1'b0;
    w_ir_load_en    = 1'b0;
    w_rf_write_read = 1'b0;
    w_rf_address    = 2'd0;
    w_a_load_en     = 1'b0;
    w_b_load_en     = 1'b0;
    w_alu_op        = 3'd0;
    w_illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (w_mem_req && bus.mem_ack) begin
          w_bus_sel    = c_bus_mem;
          w_ir_load_en = 1'b1;
          w_pc_load_en = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.ir[7]) begin
          state_d = S_RD_A;
        end else begin
          case (w_opc)
            c_op_nop:  state_d = S_FETCH;
            c_op_ldi:  state_d = S_IMM;
            c_op_mov:  state_d = S_RD_A;
            c_op_jmp:  state_d = S_IMM;
            c_op_jz:   state_d = S_IMM;
            c_op_halt: state_d = S_HALT;
            default: begin
              w_illegal_op = 1'b1;
              state_d      = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
            end
          endcase
        end
      end
      S_RD_A: begin
        w_rf_address = bus.ir[7] ? w_rd : w_rs;
        state_d      = bus.ir[7] ? S_RD_B : S_MOV_WB;
      end
      S_RD_B: begin
        // rd value read in RD_A is on the bus now; rs read is launched.
        w_rf_address = w_rs;
        w_bus_sel    = c_bus_rf;
        w_a_load_en  = 1'b1;
        state_d      = S_EXEC;
      end
      S_EXEC: begin
        w_bus_sel   = c_bus_rf;
        w_b_load_en = 1'b1;
        w_alu_op    = bus.ir[6:4];
        state_d     = S_WB;
      end
      S_WB: begin
        w_alu_op        = bus.ir[6:4];
        w_bus_sel       = c_bus_alu;
        w_rf_address    = w_rd;
        w_rf_write_read = 1'b1;
        z_flag_d        = bus.alu_zero;
        state_d         = S_FETCH;
      end
      S_MOV_WB: begin
        w_bus_sel       = c_bus_rf;
        w_rf_address    = w_rd;
        w_rf_write_read = 1'b1;
        state_d         = S_FETCH;
      end
      S_IMM: begin
        if (bus.mem_ack) begin
          w_bus_sel = c_bus_mem;
          state_d   = S_FETCH;
          case (w_opc)
            c_op_ldi: begin
              w_rf_write_read = 1'b1;
              w_rf_address    = w_rd;
              w_pc_load_en    = 1'b1;
            end
            c_op_jmp: begin
              w_pc_load_en = 1'b1;
              w_pc_src     = 1'b1;
            end
            c_op_jz: begin
              w_pc_load_en = 1'b1;
              w_pc_src     = z_flag_q;
            end
            default: ;
          endcase
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // An ack in the final allowed cycle takes priority over the timeout.
    if (w_timeout) begin
      fault_d = 1'b1;
      state_d = S_HALT;
    end
  end

  assign bus.mem_req       = w_mem_req;
  assign bus.bus_sel       = w_bus_sel;
  assign bus.pc_load_en    = w_pc_load_en;
  assign bus.pc_src        = w_pc_src;
  assign bus.ir_load_en    = w_ir_load_en;
  assign bus.rf_write_read = w_rf_write_read;
  assign bus.rf_address    = w_rf_address;
  assign bus.a_load_en     = w_a_load_en;
  assign bus.b_load_en     = w_b_load_en;
  assign bus.alu_op        = w_alu_op;
  assign bus.z_flag        = z_flag_q;
  assign bus.halted        = (state_q == S_HALT);
  assign bus.fault         = fault_q;
  assign bus.illegal_op    = w_illegal_op;

endmodule

`default_nettype wire

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: per-cycle vector table plus timeout
// and illegal-halt sequences, with expectations queued in a scoreboard.
`default_nettype none

module tb_bus_sequencer;

  typedef struct packed {
    logic       mem_req;
    logic [2:0] bus_sel;
    logic       pc_load_en;
    logic       pc_src;
    logic       ir_load_en;
    logic       rf_write_read;
    logic [1:0] rf_address;
    logic       a_load_en;
    logic       b_load_en;
    logic [2:0] alu_op;
    logic       z_flag;
    logic       halted;
    logic       fault;
    logic       illegal_op;
  } out_t;

  typedef struct {
    logic       rst;
    logic [7:0] ir;
    logic       ack;
    logic       az;
    out_t       exp;
  } vec_t;

  typedef struct {
    int    which;
    out_t  exp;
    string nm;
  } sb_t;

  logic       clock = 1'b0;
  logic       rst_r;
  logic [7:0] ir_r;
  logic       ack_r;
  logic       az_r;

  int errors = 0;
  int checks = 0;

  vec_t tbl[$];
  sb_t  sb[$];

  bus_sequencer_if if0 ();
  bus_sequencer_if if1 ();

  assign if0.ir = ir_r;  assign if0.mem_ack = ack_r;  assign if0.alu_zero = az_r;
  assign if1.ir = ir_r;  assign if1.mem_ack = ack_r;  assign if1.alu_zero = az_r;

  bus_sequencer #(.TIMEOUT_CYCLES(16), .HALT_ON_ILLEGAL(1'b0)) u_dut0 (
    .clock (clock),
    .reset (rst_r),
`ifdef SEQ_STEP_EN
    .step  (1'b1),
`endif
    .bus   (if0.master)
  );

  bus_sequencer #(.TIMEOUT_CYCLES(16), .HALT_ON_ILLEGAL(1'b1)) u_dut1 (
    .clock (clock),
    .reset (rst_r),
`ifdef SEQ_STEP_EN
    .step  (1'b1),
`endif
    .bus   (if1.master)
  );

  out_t act0, act1;
  assign act0 = {if0.mem_req, if0.bus_sel, if0.pc_load_en, if0.pc_src, if0.ir_load_en,
                 if0.rf_write_read, if0.rf_address, if0.a_load_en, if0.b_load_en,
                 if0.alu_op, if0.z_flag, if0.halted, if0.fault, if0.illegal_op};
  assign act1 = {if1.mem_req, if1.bus_sel, if1.pc_load_en, if1.pc_src, if1.ir_load_en,
                 if1.rf_write_read, if1.rf_address, if1.a_load_en, if1.b_load_en,
                 if1.alu_op, if1.z_flag, if1.halted, if1.fault, if1.illegal_op};

  always #5 clock = ~clock;

  function automatic out_t mk(input int req, input int bsel, input int pcl, input int pcs,
                              input int irl, input int wr, input int addr, input int al,
                              input int bl, input int op, input int z, input int h,
                              input int f, input int ill);
    out_t e;
    e.mem_req       = 1'(req);
    e.bus_sel       = 3'(bsel);
    e.pc_load_en    = 1'(pcl);
    e.pc_src        = 1'(pcs);
    e.ir_load_en    = 1'(irl);
    e.rf_write_read = 1'(wr);
    e.rf_address    = 2'(addr);
    e.a_load_en     = 1'(al);
    e.b_load_en     = 1'(bl);
    e.alu_op        = 3'(op);
    e.z_flag        = 1'(z);
    e.halted        = 1'(h);
    e.fault         = 1'(f);
    e.illegal_op    = 1'(ill);
    return e;
  endfunction

  // Shorthands: waiting fetch, fetch ack, quiet cycle, halted.
  function automatic out_t fq(input int z); return mk(1,0,0,0,0,0,0,0,0,0,z,0,0,0); endfunction
  function automatic out_t fa(input int z); return mk(1,2,1,0,1,0,0,0,0,0,z,0,0,0); endfunction
  function automatic out_t id(input int z); return mk(0,0,0,0,0,0,0,0,0,0,z,0,0,0); endfunction
  function automatic out_t hl(input int f); return mk(0,0,0,0,0,0,0,0,0,0,0,1,f,0); endfunction

  task automatic add(input logic r, input logic [7:0] i, input logic a, input logic z, input out_t e);
    vec_t v;
    v.rst = r; v.ir = i; v.ack = a; v.az = z; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic apply(input logic r, input logic [7:0] i, input logic a, input logic z,
                       input int which, input out_t e, input string nm);
    sb_t s;
    out_t got;
    rst_r = r; ir_r = i; ack_r = a; az_r = z;
    s.which = which; s.exp = e; s.nm = nm;
    sb.push_back(s);
    @(negedge clock);
    s = sb.pop_front();
    got = (s.which == 0) ? act0 : act1;
    checks++;
    if (got !== s.exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", s.nm, got, s.exp);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_r = 1'b1; ir_r = 8'h00; ack_r = 1'b0; az_r = 1'b0;
    @(posedge clock);
    #1;

    add(1, 8'h00, 0, 0, fq(0));                              // reset state
    add(0, 8'h00, 1, 0, fa(0));                              // 1-cycle fetch
    add(0, 8'h14, 1, 0, id(0));
    add(0, 8'h14, 1, 0, mk(1,2,1,0,0,1,1,0,0,0,0,0,0,0));   // LDI r1
    add(0, 8'h14, 1, 0, fa(0));
    add(0, 8'h86, 1, 0, id(0));
    add(0, 8'h86, 1, 0, mk(0,0,0,0,0,0,1,0,0,0,0,0,0,0));   // RD_A rd
    add(0, 8'h86, 1, 0, mk(0,3,0,0,0,0,2,1,0,0,0,0,0,0));   // RD_B
    add(0, 8'h86, 1, 0, mk(0,3,0,0,0,0,0,0,1,0,0,0,0,0));   // EXEC
    add(0, 8'h86, 1, 1, mk(0,4,0,0,0,1,1,0,0,0,0,0,0,0));   // WB, zero
    add(0, 8'h86, 1, 0, fa(1));
    add(0, 8'h40, 1, 0, id(1));
    add(0, 8'h40, 1, 0, mk(1,2,1,1,0,0,0,0,0,0,1,0,0,0));   // JZ taken
    add(0, 8'h40, 1, 0, fa(1));
    add(0, 8'h92, 1, 0, id(1));
    add(0, 8'h92, 1, 0, id(1));
    add(0, 8'h92, 1, 0, mk(0,3,0,0,0,0,2,1,0,0,1,0,0,0));
    add(1, 8'h92, 1, 0, mk(0,3,0,0,0,0,0,0,1,1,1,0,0,0));   // reset in EXEC
    add(0, 8'h92, 0, 0, fq(0));
    add(0, 8'h92, 1, 0, fa(0));
    add(0, 8'h40, 1, 0, id(0));
    add(0, 8'h40, 1, 0, mk(1,2,1,0,0,0,0,0,0,0,0,0,0,0));   // JZ not taken
    add(0, 8'h40, 1, 0, fa(0));
    add(0, 8'h50, 1, 0, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1));   // illegal
    add(0, 8'h50, 0, 0, fq(0));
    add(0, 8'h50, 1, 0, fa(0));
    add(0, 8'h27, 1, 0, id(0));
    add(0, 8'h27, 1, 0, mk(0,0,0,0,0,0,3,0,0,0,0,0,0,0));   // MOV RD_A rs
    add(0, 8'h27, 1, 0, mk(0,3,0,0,0,1,1,0,0,0,0,0,0,0));   // MOV_WB
    add(0, 8'h27, 1, 0, fa(0));
    add(0, 8'h00, 1, 0, id(0));                              // NOP
    add(0, 8'h00, 1, 0, fa(0));
    add(0, 8'h30, 1, 0, id(0));
    add(0, 8'h30, 0, 0, fq(0));                              // IMM wait
    add(0, 8'h30, 1, 0, mk(1,2,1,1,0,0,0,0,0,0,0,0,0,0));   // JMP
    add(0, 8'h30, 1, 0, fa(0));
    add(0, 8'h00, 0, 0, id(0));
    add(0, 8'h00, 0, 0, fq(0));
    add(1, 8'h00, 0, 0, fq(0));                              // reset mid-wait
    add(0, 8'h00, 0, 0, fq(0));
    add(0, 8'h00, 1, 0, fa(0));
    add(0, 8'h70, 1, 0, id(0));
    add(0, 8'h70, 1, 0, hl(0));                              // HALT
    add(0, 8'h70, 1, 0, hl(0));
    add(1, 8'h70, 1, 0, hl(0));
    add(0, 8'h00, 0, 0, fq(0));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].rst, tbl[k].ir, tbl[k].ack, tbl[k].az, 0, tbl[k].exp, $sformatf("vec%0d", k));
    end

    // Timeout: sixteen unacked request cycles then fault and halt.
    apply(1, 8'h00, 0, 0, 0, fq(0), "tmo_rst");
    for (int k = 0; k < 16; k++) apply(0, 8'h00, 0, 0, 0, fq(0), $sformatf("tmo_wait%0d", k));
    apply(0, 8'h00, 0, 0, 0, hl(1), "tmo_fault");
    apply(0, 8'h00, 1, 0, 0, hl(1), "tmo_sticky");
    apply(1, 8'h00, 0, 0, 0, hl(1), "tmo_rst2");

    // Ack in the last allowed cycle: no fault.
    for (int k = 0; k < 15; k++) apply(0, 8'h00, 0, 0, 0, fq(0), $sformatf("late_wait%0d", k));
    apply(0, 8'h00, 1, 0, 0, fa(0), "late_ack");
    apply(0, 8'h00, 0, 0, 0, id(0), "late_nofault");
    apply(0, 8'h00, 0, 0, 0, fq(0), "late_refetch");

    // HALT_ON_ILLEGAL=1 instance.
    apply(1, 8'h00, 0, 0, 1, fq(0), "hoi_rst");
    apply(0, 8'h00, 1, 0, 1, fa(0), "hoi_fetch");
    apply(0, 8'h50, 1, 0, 1, mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1), "hoi_illegal");
    apply(0, 8'h50, 1, 0, 1, hl(0), "hoi_halt");
    apply(0, 8'h50, 1, 0, 1, hl(0), "hoi_halt_hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
